// File: rtl/hex_line_formatter.sv
// Drains NBYTES bytes from the readback stage and streams them to the UART as
// hex-dump lines: "OOOO: HH HH ... \r\n", one character per tx_start/tx_busy handshake.
module hex_line_formatter #(
    parameter int NBYTES = 512,
    parameter int BPL    = 16,
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       next,
    output logic [7:0] tx_dat,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_OFS   = 4'd1;
    localparam logic [3:0] S_COLON = 4'd2;
    localparam logic [3:0] S_SP0   = 4'd3;
    localparam logic [3:0] S_FETCH = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_HI    = 4'd6;
    localparam logic [3:0] S_LO    = 4'd7;
    localparam logic [3:0] S_SP    = 4'd8;
    localparam logic [3:0] S_CR    = 4'd9;
    localparam logic [3:0] S_LF    = 4'd10;
    localparam logic [3:0] S_FIN   = 4'd11;

    logic [3:0]  state_reg;
    logic [1:0]  phase_reg;
    logic [1:0]  digit_reg;
    logic [15:0] byte_cnt_reg;
    logic [15:0] line_ofs_reg;
    logic [7:0]  line_cnt_reg;
    logic [7:0]  lat_reg;
    logic [7:0]  hold_reg;
    logic [7:0]  tx_dat_reg;
    logic        tx_start_reg;
    logic        next_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [15:0] ofs_shift;
    logic [15:0] cnt_inc;
    logic [7:0]  line_inc;
    logic [7:0]  ch;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign ofs_shift = line_ofs_reg << {digit_reg, 2'b00};
    assign cnt_inc   = byte_cnt_reg + 16'd1;
    assign line_inc  = line_cnt_reg + 8'd1;

    always_comb begin
        ch = 8'h00;
        case (state_reg)
            S_OFS:        ch = hex_ascii(ofs_shift[15:12]);
            S_COLON:      ch = 8'h3A;
            S_SP0, S_SP:  ch = 8'h20;
            S_HI:         ch = hex_ascii(hold_reg[7:4]);
            S_LO:         ch = hex_ascii(hold_reg[3:0]);
            S_CR:         ch = 8'h0D;
            S_LF:         ch = 8'h0A;
            default:      ch = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            phase_reg    <= 2'd0;
            digit_reg    <= 2'd0;
            byte_cnt_reg <= 16'd0;
            line_ofs_reg <= 16'd0;
            line_cnt_reg <= 8'd0;
            lat_reg      <= 8'd0;
            hold_reg     <= 8'd0;
            tx_dat_reg   <= 8'd0;
            tx_start_reg <= 1'b0;
            next_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            next_reg     <= 1'b0;
            tx_start_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg     <= 1'b1;
                        byte_cnt_reg <= 16'd0;
                        line_ofs_reg <= 16'd0;
                        line_cnt_reg <= 8'd0;
                        digit_reg    <= 2'd0;
                        phase_reg    <= 2'd0;
                        state_reg    <= S_OFS;
                    end
                end
                S_FETCH: begin
                    next_reg  <= 1'b1;
                    lat_reg   <= 8'(RD_LAT);
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // byte_in is only trusted in the cycle the latency count expires
                    if (lat_reg == 8'd0) begin
                        hold_reg  <= byte_in;
                        state_reg <= S_HI;
                    end else begin
                        lat_reg <= lat_reg - 8'd1;
                    end
                end
                S_FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                S_OFS, S_COLON, S_SP0, S_HI, S_LO, S_SP, S_CR, S_LF: begin
                    // phase 0: wait idle UART; 1-2: blind to tx_busy rise; 3: wait idle, advance
                    case (phase_reg)
                        2'd0: begin
                            if (!tx_busy) begin
                                tx_dat_reg   <= ch;
                                tx_start_reg <= 1'b1;
                                phase_reg    <= 2'd1;
                            end
                        end
                        2'd1: phase_reg <= 2'd2;
                        2'd2: phase_reg <= 2'd3;
                        default: begin
                            if (!tx_busy) begin
                                phase_reg <= 2'd0;
                                case (state_reg)
                                    S_OFS: begin
                                        digit_reg <= digit_reg + 2'd1;
                                        if (digit_reg == 2'd3) state_reg <= S_COLON;
                                    end
                                    S_COLON: state_reg <= S_SP0;
                                    S_SP0:   state_reg <= S_FETCH;
                                    S_HI:    state_reg <= S_LO;
                                    S_LO:    state_reg <= S_SP;
                                    S_SP: begin
                                        byte_cnt_reg <= cnt_inc;
                                        line_cnt_reg <= (line_inc == 8'(BPL)) ? 8'd0 : line_inc;
                                        if (cnt_inc == 16'(NBYTES) || line_inc == 8'(BPL))
                                            state_reg <= S_CR;
                                        else
                                            state_reg <= S_FETCH;
                                    end
                                    S_CR:    state_reg <= S_LF;
                                    default: begin
                                        line_ofs_reg <= byte_cnt_reg;
                                        digit_reg    <= 2'd0;
                                        state_reg    <= (byte_cnt_reg == 16'(NBYTES)) ? S_FIN : S_OFS;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign next     = next_reg;
    assign tx_dat   = tx_dat_reg;
    assign tx_start = tx_start_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_hex_line_formatter.sv
// Scoreboard bench: two formatters (4 bytes and 3 bytes, 2 per line) with readback and UART models.
module tb_hex_line_formatter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic hold = 1'b0;
    logic end_chk = 1'b0;

    logic [7:0] byte_in_a = 8'h00, byte_in_b = 8'h00;
    logic [7:0] tx_dat_a, tx_dat_b;
    logic next_a, tx_start_a, busy_a, done_a, tx_busy_a;
    logic next_b, tx_start_b, busy_b, done_b, tx_busy_b;

    int bcnt_a = 0, bcnt_b = 0;
    int idx_a = 0, idx_b = 0;
    logic pend_a = 1'b0, pend_b = 1'b0;
    logic [7:0] data_a [4] = '{8'h3A, 8'hF0, 8'h00, 8'hFF};
    logic [7:0] data_b [3] = '{8'h09, 8'hA0, 8'h5C};
    logic [7:0] rb_a, rb_b;

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int exp_tx_a, exp_tx_b, exp_nx_a, exp_nx_b;

    int total = 0, bad = 0;
    int tx_cnt_a = 0, tx_cnt_b = 0, nx_cnt_a = 0, nx_cnt_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0, drop_a = 0, drop_b = 0;
    int since_a = 100, since_b = 100;
    logic run_a = 1'b0, run_b = 1'b0;

    always #5 clk = ~clk;

    hex_line_formatter #(.NBYTES(4), .BPL(2), .RD_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in_a), .next(next_a),
        .tx_dat(tx_dat_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a),
        .busy(busy_a), .done(done_a)
    );

    hex_line_formatter #(.NBYTES(3), .BPL(2), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in_b), .next(next_b),
        .tx_dat(tx_dat_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b),
        .busy(busy_b), .done(done_b)
    );

    // UART: busy for 10 cycles after each strobe, or forced busy by hold
    assign tx_busy_a = (bcnt_a != 0) || hold;
    assign tx_busy_b = (bcnt_b != 0) || hold;
    always @(posedge clk) begin
        if (tx_start_a) bcnt_a <= 10; else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
        if (tx_start_b) bcnt_b <= 10; else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    end

    // Readback: a wrong value at next+1, the requested byte from next+2
    assign rb_a = (idx_a < 4) ? data_a[idx_a] : 8'hEE;
    assign rb_b = (idx_b < 3) ? data_b[idx_b] : 8'hEE;
    always @(posedge clk) begin
        if (clr) begin
            idx_a <= 0; pend_a <= 1'b0; idx_b <= 0; pend_b <= 1'b0;
        end else begin
            if (next_a) begin
                pend_a <= 1'b1; byte_in_a <= ~rb_a;
            end else if (pend_a) begin
                pend_a <= 1'b0; byte_in_a <= rb_a; idx_a <= idx_a + 1;
            end
            if (next_b) begin
                pend_b <= 1'b1; byte_in_b <= ~rb_b;
            end else if (pend_b) begin
                pend_b <= 1'b0; byte_in_b <= rb_b; idx_b <= idx_b + 1;
            end
        end
    end

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every tx_start and tallies events
    initial forever begin
        @(negedge clk);
        if (clr) begin
            tx_cnt_a = 0; tx_cnt_b = 0; nx_cnt_a = 0; nx_cnt_b = 0;
            done_cnt_a = 0; done_cnt_b = 0; drop_a = 0; drop_b = 0;
            since_a = 100; since_b = 100; run_a = 1'b0; run_b = 1'b0;
        end else begin
            if (rst) begin
                chk("reset_outputs_a", int'({next_a, tx_start_a, tx_dat_a, busy_a, done_a}), 0);
                chk("reset_outputs_b", int'({next_b, tx_start_b, tx_dat_b, busy_b, done_b}), 0);
            end
            if (tx_start_a) begin
                chk("tx_gap_a", int'(since_a >= 3), 1);
                chk("tx_start_uart_busy_a", int'(tx_busy_a), 0);
                if (exp_a.size() == 0) chk("extra_char_a", 1, 0);
                else chk("char_a", int'(tx_dat_a), int'(exp_a.pop_front()));
                $display("A char %0d = %02h", tx_cnt_a, tx_dat_a);
                tx_cnt_a++; since_a = 0;
            end else if (since_a < 1000) since_a++;
            if (tx_start_b) begin
                chk("tx_gap_b", int'(since_b >= 3), 1);
                chk("tx_start_uart_busy_b", int'(tx_busy_b), 0);
                if (exp_b.size() == 0) chk("extra_char_b", 1, 0);
                else chk("char_b", int'(tx_dat_b), int'(exp_b.pop_front()));
                $display("B char %0d = %02h", tx_cnt_b, tx_dat_b);
                tx_cnt_b++; since_b = 0;
            end else if (since_b < 1000) since_b++;
            if (next_a) nx_cnt_a++;
            if (next_b) nx_cnt_b++;
            if (done_a) begin done_cnt_a++; run_a = 1'b0; end
            else if (busy_a) run_a = 1'b1;
            else if (run_a) drop_a++;
            if (done_b) begin done_cnt_b++; run_b = 1'b0; end
            else if (busy_b) run_b = 1'b1;
            else if (run_b) drop_b++;
        end
        if (end_chk) begin
            chk("tx_count_a", tx_cnt_a, exp_tx_a);
            chk("tx_count_b", tx_cnt_b, exp_tx_b);
            chk("next_count_a", nx_cnt_a, exp_nx_a);
            chk("next_count_b", nx_cnt_b, exp_nx_b);
            chk("done_count_a", done_cnt_a, 1);
            chk("done_count_b", done_cnt_b, 1);
            chk("busy_drop_a", drop_a, 0);
            chk("busy_drop_b", drop_b, 0);
            chk("chars_left_a", exp_a.size(), 0);
            chk("chars_left_b", exp_b.size(), 0);
            chk("busy_idle_a", int'(busy_a), 0);
            chk("busy_idle_b", int'(busy_b), 0);
        end
    end

    // '~' in the text stands for CR LF
    task automatic push_str(input bit which, input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            if (c == 8'h7E) begin
                if (which) begin exp_b.push_back(8'h0D); exp_b.push_back(8'h0A); end
                else begin exp_a.push_back(8'h0D); exp_a.push_back(8'h0A); end
            end else if (which) exp_b.push_back(c);
            else exp_a.push_back(c);
        end
    endtask

    task automatic push_all();
        push_str(1'b0, "0000: 3A F0 ~0002: 00 FF ~");
        push_str(1'b1, "0000: 09 A0 ~0002: 5C ~");
        exp_tx_a = 28; exp_nx_a = 4;
        exp_tx_b = 25; exp_nx_b = 3;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt_a >= 1 && done_cnt_b >= 1) break;
        end
        repeat (3) @(posedge clk);
        #1 end_chk = 1'b1;
        @(posedge clk); #1 end_chk = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic dump with latency-shaped readback
        pulse_clr();
        push_all();
        pulse_start();
        wait_done();

        // Extra start pulses during the dump are ignored
        pulse_clr();
        push_all();
        fork
            begin
                pulse_start();
                repeat (15) begin
                    repeat (13) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            end
            wait_done();
        join

        // UART held busy before the first character
        pulse_clr();
        #1 hold = 1'b1;
        push_all();
        pulse_start();
        repeat (500) @(posedge clk);
        #1 hold = 1'b0;
        wait_done();

        // Asynchronous reset just after the first HI digit, then a clean restart
        pulse_clr();
        push_all();
        pulse_start();
        for (int i = 0; i < 1000 && tx_cnt_a < 7; i++) @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
        pulse_clr();
        push_all();
        pulse_start();
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
